// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - column-strobed key matrix scanner with frame debounce and key events
// A single key gives press/release/repeat events; chords are flagged and suppressed until full release.
module keypad_matrix_scanner #(
   parameter int ROWS            = 4,
   parameter int COLS            = 4,
   parameter int SCAN_DIV        = 50,
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int REPEAT_FRAMES   = 0,
   localparam int RW             = $clog2(ROWS),
   localparam int CW             = $clog2(COLS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ROWS-1:0]  keyboard_row,
   output logic [COLS-1:0]  keyboard_col,
   output logic             key_valid,
   output logic             key_up,
   output logic [RW+CW-1:0] key_code,
   output logic             key_pressed,
   output logic             multi_key
);
   localparam int N  = ROWS * COLS;
   localparam int DW = $clog2(SCAN_DIV);
   localparam int SW = $clog2(DEBOUNCE_FRAMES + 1);
   localparam int PW = $clog2(REPEAT_FRAMES + 2);

   typedef enum logic [1:0] {IDLE, HELD, SWAP, MULTI} state_t;

   logic [ROWS-1:0]  row_s1_q, row_s1_d, row_s2_q, row_s2_d;
   logic [DW-1:0]    dwell_q, dwell_d;
   logic [CW-1:0]    col_q, col_d;
   logic [COLS-1:0]  kcol_q, kcol_d;
   logic [N-1:0]     acc_q, acc_d, raw_q, raw_d, deb_q, deb_d;
   logic [SW-1:0]    stab_q, stab_d;
   logic [PW-1:0]    rep_q, rep_d;
   state_t           state_q, state_d;
   logic [RW+CW-1:0] code_q, code_d;
   logic             valid_q, valid_d, up_q, up_d, pressed_q, pressed_d, multi_q, multi_d;

   logic [N-1:0]     new_frame;
   logic             sample, frame_end;
   logic [1:0]       n_keys;
   logic [RW-1:0]    hit_r;
   logic [CW-1:0]    hit_c;
   logic [RW+CW-1:0] hit_code;

   always_comb begin
      row_s1_d  = keyboard_row;
      row_s2_d  = row_s1_q;
      dwell_d   = dwell_q + DW'(1);
      col_d     = col_q;
      kcol_d    = kcol_q;
      acc_d     = acc_q;
      raw_d     = raw_q;
      deb_d     = deb_q;
      stab_d    = stab_q;
      rep_d     = rep_q;
      state_d   = state_q;
      code_d    = code_q;
      valid_d   = 1'b0;
      up_d      = 1'b0;
      n_keys    = 2'd0;
      hit_r     = '0;
      hit_c     = '0;

      sample    = (dwell_q == DW'(SCAN_DIV - 1));
      frame_end = sample && (col_q == CW'(COLS - 1));

      // Frame bit r*COLS+c is 1 when key (r,c) is down
      new_frame = acc_q;
      for (int r = 0; r < ROWS; r++)
         new_frame[r*COLS + int'(col_q)] = ~row_s2_q[ROWS-1-r];

      if (sample) begin
         dwell_d = '0;
         acc_d   = new_frame;
         col_d   = frame_end ? '0 : col_q + CW'(1);
         for (int c = 0; c < COLS; c++)
            kcol_d[COLS-1-c] = (col_d != CW'(c));
      end

      if (frame_end) begin
         raw_d = new_frame;
         if (new_frame != raw_q)
            stab_d = SW'(1);
         else if (stab_q != SW'(DEBOUNCE_FRAMES))
            stab_d = stab_q + SW'(1);
         if (stab_d == SW'(DEBOUNCE_FRAMES))
            deb_d = new_frame;
      end

      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (deb_d[r*COLS + c]) begin
               if (n_keys == 2'd0) begin
                  hit_r = RW'(r);
                  hit_c = CW'(c);
               end
               if (n_keys != 2'd2)
                  n_keys = n_keys + 2'd1;
            end
         end
      end
      hit_code = {hit_r, hit_c};

      // SWAP: key_up already sent for the old key; the new key is reported next frame
      if (frame_end) begin
         case (state_q)
            IDLE: begin
               if (n_keys == 2'd1) begin
                  state_d = HELD;
                  valid_d = 1'b1;
                  code_d  = hit_code;
                  rep_d   = '0;
               end else if (n_keys == 2'd2) begin
                  state_d = MULTI;
               end
            end
            HELD: begin
               if (n_keys == 2'd0) begin
                  state_d = IDLE;
                  up_d    = 1'b1;
               end else if (n_keys == 2'd2) begin
                  state_d = MULTI;
                  up_d    = 1'b1;
               end else if (hit_code != code_q) begin
                  state_d = SWAP;
                  up_d    = 1'b1;
               end else if (REPEAT_FRAMES > 0) begin
                  if (rep_q + PW'(1) == PW'(REPEAT_FRAMES)) begin
                     valid_d = 1'b1;
                     rep_d   = '0;
                  end else begin
                     rep_d = rep_q + PW'(1);
                  end
               end
            end
            SWAP: begin
               if (n_keys == 2'd0) begin
                  state_d = IDLE;
               end else if (n_keys == 2'd2) begin
                  state_d = MULTI;
               end else begin
                  state_d = HELD;
                  valid_d = 1'b1;
                  code_d  = hit_code;
                  rep_d   = '0;
               end
            end
            default: begin
               if (n_keys == 2'd0)
                  state_d = IDLE;
            end
         endcase
      end

      pressed_d = (state_d == HELD) || (state_d == SWAP);
      multi_d   = (state_d == MULTI);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_s1_q  <= '1;
         row_s2_q  <= '1;
         dwell_q   <= '0;
         col_q     <= '0;
         kcol_q    <= {1'b0, {(COLS-1){1'b1}}};
         acc_q     <= '0;
         raw_q     <= '0;
         deb_q     <= '0;
         stab_q    <= '0;
         rep_q     <= '0;
         state_q   <= IDLE;
         code_q    <= '0;
         valid_q   <= 1'b0;
         up_q      <= 1'b0;
         pressed_q <= 1'b0;
         multi_q   <= 1'b0;
      end else begin
         row_s1_q  <= row_s1_d;
         row_s2_q  <= row_s2_d;
         dwell_q   <= dwell_d;
         col_q     <= col_d;
         kcol_q    <= kcol_d;
         acc_q     <= acc_d;
         raw_q     <= raw_d;
         deb_q     <= deb_d;
         stab_q    <= stab_d;
         rep_q     <= rep_d;
         state_q   <= state_d;
         code_q    <= code_d;
         valid_q   <= valid_d;
         up_q      <= up_d;
         pressed_q <= pressed_d;
         multi_q   <= multi_d;
      end
   end

   assign keyboard_col = kcol_q;
   assign key_valid    = valid_q;
   assign key_up       = up_q;
   assign key_code     = code_q;
   assign key_pressed  = pressed_q;
   assign multi_key    = multi_q;
endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// tb/tb_keypad_matrix_scanner.sv - directed bench for keypad_matrix_scanner
// Three instances: defaults, auto-repeat every 5 frames, and an 8x8 matrix with a short dwell.
module tb_keypad_matrix_scanner;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [15:0] a_keys = '0;
   logic [15:0] r_keys = '0;
   logic [63:0] b_keys = '0;

   logic [3:0] a_row, a_col, a_code, r_row, r_col, r_code;
   logic       a_valid, a_up, a_pressed, a_multi;
   logic       r_valid, r_up, r_pressed, r_multi;
   logic [7:0] b_row, b_col;
   logic [5:0] b_code;
   logic       b_valid, b_up, b_pressed, b_multi;

   int a_nv = 0, a_nu = 0, r_nv = 0, r_nu = 0, b_nv = 0, b_nu = 0;
   int r_badcode = 0, n_overlap = 0;
   int n_cmp = 0, n_bad = 0;

   keypad_matrix_scanner u_a (
      .clk(clk), .rst(rst), .keyboard_row(a_row), .keyboard_col(a_col),
      .key_valid(a_valid), .key_up(a_up), .key_code(a_code),
      .key_pressed(a_pressed), .multi_key(a_multi));

   keypad_matrix_scanner #(.REPEAT_FRAMES(5)) u_r (
      .clk(clk), .rst(rst), .keyboard_row(r_row), .keyboard_col(r_col),
      .key_valid(r_valid), .key_up(r_up), .key_code(r_code),
      .key_pressed(r_pressed), .multi_key(r_multi));

   keypad_matrix_scanner #(.ROWS(8), .COLS(8), .SCAN_DIV(8)) u_b (
      .clk(clk), .rst(rst), .keyboard_row(b_row), .keyboard_col(b_col),
      .key_valid(b_valid), .key_up(b_up), .key_code(b_code),
      .key_pressed(b_pressed), .multi_key(b_multi));

   // Key (r,c) shorts row r to column c: row bit R-1-r low while column bit C-1-c is strobed low
   always_comb begin
      a_row = '1;
      r_row = '1;
      b_row = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            if (a_keys[r*4+c] && !a_col[3-c]) a_row[3-r] = 1'b0;
            if (r_keys[r*4+c] && !r_col[3-c]) r_row[3-r] = 1'b0;
         end
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 8; c++)
            if (b_keys[r*8+c] && !b_col[7-c]) b_row[7-r] = 1'b0;
   end

   always @(negedge clk) begin
      if (a_valid) a_nv++;
      if (a_up)    a_nu++;
      if (r_valid) r_nv++;
      if (r_up)    r_nu++;
      if (b_valid) b_nv++;
      if (b_up)    b_nu++;
      if (r_valid && r_code != 4'h5) r_badcode++;
      if ((a_valid && a_up) || (r_valid && r_up) || (b_valid && b_up)) n_overlap++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   int  v0, u0, v1, u1, lat;
   bit  seen, ok, found;
   logic [7:0] exp_col;

   initial begin
      rst = 1'b1;
      cycles(3);
      check("rst_col_a", a_col, 4'b0111);
      check("rst_valid", a_valid, 1'b0);
      check("rst_up", a_up, 1'b0);
      check("rst_code", a_code, 4'h0);
      check("rst_pressed", a_pressed, 1'b0);
      check("rst_multi", a_multi, 1'b0);
      check("rst_col_b", b_col, 8'h7F);
      rst = 1'b0;

      // Clean press of row 2 / col 3 starting at a frame boundary
      seen = 0; ok = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (a_col == 4'b1110) seen = 1;
         else if (seen && a_col == 4'b0111) begin ok = 1; break; end
      end
      check("t1_frame_sync", ok, 1'b1);
      v0 = a_nv; u0 = a_nu;
      a_keys[11] = 1'b1;
      lat = 0; found = 0;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (a_valid) begin found = 1; break; end
      end
      check("t1_valid_seen", found, 1'b1);
      check("t1_latency_window", (lat >= 600 && lat <= 800), 1'b1);
      check("t1_code", a_code, 4'hB);
      check("t1_pressed", a_pressed, 1'b1);
      cycles(2000 - lat);
      check("t1_single_valid", a_nv - v0, 1);
      check("t1_no_up_while_held", a_nu - u0, 0);
      a_keys = '0;
      cycles(900);
      check("t1_one_up", a_nu - u0, 1);
      check("t1_released", a_pressed, 1'b0);
      check("t1_code_held", a_code, 4'hB);

      // Contact bounce on key 0x6 then steady
      v0 = a_nv; u0 = a_nu;
      for (int i = 0; i < 7; i++) begin
         a_keys[6] = ~a_keys[6];
         cycles(70);
      end
      check("t2_quiet_bounce", a_nv - v0, 0);
      cycles(800);
      check("t2_one_valid", a_nv - v0, 1);
      check("t2_code", a_code, 4'h6);
      a_keys = '0;
      cycles(900);
      check("t2_one_up", a_nu - u0, 1);

      // Chord 0x2 + 0x9
      v0 = a_nv; u0 = a_nu;
      a_keys[2] = 1'b1; a_keys[9] = 1'b1;
      cycles(900);
      check("t3_multi_set", a_multi, 1'b1);
      check("t3_not_pressed", a_pressed, 1'b0);
      a_keys[9] = 1'b0;
      cycles(900);
      check("t3_multi_kept", a_multi, 1'b1);
      check("t3_no_valid", a_nv - v0, 0);
      a_keys = '0;
      cycles(900);
      check("t3_multi_clear", a_multi, 1'b0);
      check("t3_no_up", a_nu - u0, 0);
      check("t3_no_valid_end", a_nv - v0, 0);

      // Auto-repeat: 0x5 held for 30 frames
      v0 = r_nv; u0 = r_nu;
      r_keys[5] = 1'b1;
      cycles(6000);
      r_keys[5] = 1'b0;
      cycles(900);
      check("t4_valid_count", r_nv - v0, 6);
      check("t4_codes", r_badcode, 0);
      check("t4_code", r_code, 4'h5);
      check("t4_one_up", r_nu - u0, 1);

      // Reset while 0x7 is held
      v0 = a_nv; u0 = a_nu;
      a_keys[7] = 1'b1;
      cycles(900);
      check("t5_held", a_pressed, 1'b1);
      check("t5_code", a_code, 4'h7);
      rst = 1'b1;
      #1;
      check("t5_rst_col", a_col, 4'b0111);
      check("t5_rst_pressed", a_pressed, 1'b0);
      check("t5_rst_code", a_code, 4'h0);
      v1 = a_nv; u1 = a_nu;
      cycles(3);
      rst = 1'b0;
      check("t5_no_pulse_in_rst", (a_nv - v1) + (a_nu - u1), 0);
      cycles(900);
      check("t5_repress", a_nv - v1, 1);
      check("t5_code_again", a_code, 4'h7);
      check("t5_no_up", a_nu - u0, 0);
      a_keys = '0;
      cycles(900);

      // 8x8 strobe walk and row 7 / col 0
      seen = 0; ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (b_col == 8'hFE) seen = 1;
         else if (seen && b_col == 8'h7F) begin ok = 1; break; end
      end
      check("t6_frame_sync", ok, 1'b1);
      for (int c = 0; c < 8; c++) begin
         exp_col = ~(8'h80 >> c);
         check("t6_strobe", b_col, exp_col);
         cycles(8);
      end
      v0 = b_nv; u0 = b_nu;
      b_keys[56] = 1'b1;
      cycles(400);
      check("t6_one_valid", b_nv - v0, 1);
      check("t6_code", b_code, 6'h38);
      check("t6_pressed", b_pressed, 1'b1);
      b_keys = '0;
      cycles(300);
      check("t6_one_up", b_nu - u0, 1);
      check("t6_released", b_pressed, 1'b0);

      check("no_same_cycle_pulses", n_overlap, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
